berger_one_scrubber: RTL and testbench
======================================

Name: berger_one_scrubber

Overview:
- Read-side sweep engine for the Berger-protected 16x12 memory.
- On `start`, it reads every address in order through the memory read port and recomputes the ones-count of each data field.
- It compares that count against the stored check field and accumulates error statistics.
- It sits beside the write path and shares the memory's read port; the write/encode side is unchanged.

Parameters:
- ADDR_WIDTH, 4, memory address width; the sweep covers 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, data field width.
- CHECK_WIDTH, 4, check field width; must equal clog2(DATA_WIDTH+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle sweep request; sampled only in IDLE.
- mem_rd_en  output  1  read strobe to memory.
- mem_addr  output  ADDR_WIDTH  read address.
- mem_rdata  input  DATA_WIDTH+CHECK_WIDTH  codeword `{data, check}`; valid the cycle after mem_rd_en.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at sweep end.
- err_pulse  output  1  one-cycle pulse per mismatching word.
- err_count  output  ADDR_WIDTH+1  mismatches in the last or current sweep.
- first_err_addr  output  ADDR_WIDTH  address of the first mismatch in the sweep.
- first_err_valid  output  1  first_err_addr holds a valid address.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset is asynchronous and may occur mid-sweep; the sweep is abandoned, no done pulse is issued, and no statistics are kept.
- Codeword format: `mem_rdata[DATA_WIDTH+CHECK_WIDTH-1:CHECK_WIDTH]` is data and `mem_rdata[CHECK_WIDTH-1:0]` is check. A word is in error iff popcount(data) != check.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: a start pulse moves to SWEEP and clears err_count, first_err_valid and first_err_addr. A start pulse in any other state is ignored.
- SWEEP:
  - mem_rd_en=1 and mem_addr=cur; cur increments each cycle starting at 0.
  - When cur = 2^ADDR_WIDTH-1, the FSM goes to DRAIN and cur wraps to 0.
- DRAIN: mem_rd_en=0; the last read word is checked here; the FSM then goes to DONE.
- DONE: done=1 for one cycle, then the FSM returns to IDLE.
- busy is 1 in SWEEP, DRAIN and DONE.
- Check pipeline:
  - A registered flag chk_v equals the previous cycle's mem_rd_en, and chk_addr equals the previous cycle's mem_addr.
  - When chk_v is set and the word mismatches, err_pulse asserts combinationally from mem_rdata in that cycle.
  - On the same clock edge err_count increments; the register update is visible the next cycle.
  - If first_err_valid=0, first_err_addr<=chk_addr and first_err_valid<=1.
- Timing: start is accepted at edge 0. Reads are issued in cycles 1..16 (ADDR_WIDTH=4) and checks occur in cycles 2..17. DRAIN is cycle 17 and done is cycle 18. Total latency is 2^ADDR_WIDTH+2 cycles after start.
- err_count width holds 2^ADDR_WIDTH exactly; there is no overflow and no saturation logic.
- Statistics hold their values after done until the next accepted start.
- Check-field width: check is a CHECK_WIDTH-bit field compared against the full popcount. Values above DATA_WIDTH in the check field (e.g. 9..15) are always errors.

Optional Feature:
- Macro: BERGER_SCRUB_ERRMAP_EN.
- Defined:
  - Adds output port `err_map`, width 2^ADDR_WIDTH.
  - Bit chk_addr is set whenever a mismatch is checked.
  - The whole map is cleared on an accepted start and on reset.
  - err_map is held after done.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package berger_one_pkg holds:
  - constants DATA_W=8, CHECK_W=4, ADDR_W=4;
  - the FSM state enum `scrub_state_t` {IDLE, SWEEP, DRAIN, DONE};
  - the popcount function.
- One sub-module is natural: berger_one_check. It is combinational: codeword in, `data_out` and `mismatch` out. It is instantiated once inside the scrubber.

Test Plan:
- Clean memory with all 16 words = `{data, popcount(data)}`, e.g. addr 3 = 0xA54 (data 0xA5, count 4). Start -> 16 reads at addr 0..15 in cycles 1..16; done in cycle 18; err_count=0; first_err_valid=0; err_pulse never high.
- Corrupt addr 5 = 0xA74 (data 0xA7, count 5 vs check 4) and addr 12 = 0x00F. Start -> err_pulse in cycles 7 and 14; err_count=2; first_err_addr=5; err_map=0x1020 with the macro defined.
- All 16 words = 0xFF0. Start -> err_count=16 with no wrap to 0; first_err_addr=0.
- Pulse start again in cycle 5 of a sweep -> ignored; done still in cycle 18; statistics cover a single sweep.
- Assert rst in cycle 9 -> all outputs 0 and IDLE within the same cycle; no done pulse; a new start gives a full fresh sweep.
- Two back-to-back sweeps, the first with 3 errors and the second clean -> after the second done, err_count=0 and first_err_valid=0; statistics are cleared at the accepted start.

Source files
------------

// File: rtl/berger_one_pkg.sv
// berger_one_pkg: shared constants, scrubber FSM states and popcount helper.
package berger_one_pkg;
  localparam int DATA_W = 8;
  localparam int CHECK_W = 4;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} scrub_state_t;
  function automatic logic [5:0] popcount(input logic [31:0] d);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + 6'(d[i]);
  endfunction
endpackage

// File: rtl/berger_one_check.sv
// berger_one_check: splits a Berger codeword and flags data/check disagreement.
module berger_one_check
  import berger_one_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int CHECK_WIDTH = CHECK_W
) (
  input  logic [DATA_WIDTH+CHECK_WIDTH-1:0] codeword,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              mismatch
);
  assign data_out = codeword[DATA_WIDTH+CHECK_WIDTH-1:CHECK_WIDTH];
  // full check field is compared, so values above DATA_WIDTH always mismatch
  assign mismatch = popcount(32'(data_out)) != 6'(codeword[CHECK_WIDTH-1:0]);
endmodule

// File: rtl/berger_one_scrubber.sv
// berger_one_scrubber: sweeps all memory words and tallies Berger check errors.
// Define BERGER_SCRUB_ERRMAP_EN to add the per-address err_map output.
module berger_one_scrubber
  import berger_one_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int CHECK_WIDTH = CHECK_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              mem_rd_en,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH+CHECK_WIDTH-1:0] mem_rdata,
  output logic                              busy,
  output logic                              done,
  output logic                              err_pulse,
  output logic [ADDR_WIDTH:0]               err_count,
  output logic [ADDR_WIDTH-1:0]             first_err_addr,
  output logic                              first_err_valid
`ifdef BERGER_SCRUB_ERRMAP_EN
  ,
  output logic [2**ADDR_WIDTH-1:0]          err_map
`endif
);
  scrub_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d, chk_addr_q, faddr_q;
  logic [ADDR_WIDTH:0] cnt_q;
  logic chk_v_q, fvalid_q, mismatch, accept;
  logic [DATA_WIDTH-1:0] unused_data;
`ifdef BERGER_SCRUB_ERRMAP_EN
  logic [2**ADDR_WIDTH-1:0] map_q;
  assign err_map = map_q;
`endif

  berger_one_check #(.DATA_WIDTH(DATA_WIDTH), .CHECK_WIDTH(CHECK_WIDTH)) u_check (
    .codeword(mem_rdata),
    .data_out(unused_data),
    .mismatch(mismatch)
  );

  assign accept = state_q == IDLE && start;
  assign mem_rd_en = state_q == SWEEP;
  assign mem_addr = cur_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err_pulse = chk_v_q && mismatch;
  assign err_count = cnt_q;
  assign first_err_addr = faddr_q;
  assign first_err_valid = fvalid_q;

  always_comb begin
    state_d = accept ? SWEEP :
              (state_q == SWEEP && cur_q == '1) ? DRAIN :
              state_q == DRAIN ? DONE :
              state_q == DONE ? IDLE : state_q;
    cur_d = state_q == SWEEP ? cur_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      chk_v_q <= 1'b0;
      chk_addr_q <= '0;
      cnt_q <= '0;
      faddr_q <= '0;
      fvalid_q <= 1'b0;
`ifdef BERGER_SCRUB_ERRMAP_EN
      map_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      chk_v_q <= mem_rd_en;
      chk_addr_q <= mem_addr;
      if (accept) begin
        cnt_q <= '0;
        faddr_q <= '0;
        fvalid_q <= 1'b0;
`ifdef BERGER_SCRUB_ERRMAP_EN
        map_q <= '0;
`endif
      end else if (err_pulse) begin
        cnt_q <= cnt_q + 1'b1;
        if (!fvalid_q) begin
          faddr_q <= chk_addr_q;
          fvalid_q <= 1'b1;
        end
`ifdef BERGER_SCRUB_ERRMAP_EN
        map_q[chk_addr_q] <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_berger_one_scrubber.sv
// tb_berger_one_scrubber: scoreboard bench with a behavioural memory-sweep model.
module tb_berger_one_scrubber;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic mem_rd_en, busy, done, err_pulse, first_err_valid;
  logic [3:0] mem_addr, first_err_addr;
  logic [11:0] mem_rdata = '0;
  logic [4:0] err_count;
`ifdef BERGER_SCRUB_ERRMAP_EN
  logic [15:0] err_map;
`endif
  logic [11:0] mem [N];

  typedef struct packed {
    logic [4:0]  cnt;
    logic [3:0]  faddr;
    logic        fvalid;
    logic [15:0] map;
  } exp_t;
  exp_t sb[$];
  exp_t last;
  int compared = 0, mismatched = 0;
  int cyc = 0;
  logic [15:0] pmap = '0;
  bit rd_ok = 1'b1, post = 1'b0;

  berger_one_scrubber dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err_pulse(err_pulse),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_valid(first_err_valid)
`ifdef BERGER_SCRUB_ERRMAP_EN
    , .err_map(err_map)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e = '0;
    for (int a = 0; a < N; a++)
      if ($countones(mem[a][11:4]) != int'(mem[a][3:0])) begin
        if (!e.fvalid) begin
          e.fvalid = 1'b1;
          e.faddr = 4'(a);
        end
        e.cnt = e.cnt + 5'd1;
        e.map[a] = 1'b1;
      end
    return e;
  endfunction

  // monitor: reconstructs per-sweep behaviour from the DUT pins and pops on done
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
      post = 1'b0;
      sb.delete();
    end else begin
      if (post) begin
        post = 1'b0;
        chk("done_width", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("count_hold", 32'(err_count), 32'(last.cnt));
      end
      if (busy) begin
        cyc = cyc + 1;
        if (cyc == 1) begin
          pmap = '0;
          rd_ok = 1'b1;
        end
        if (mem_rd_en !== (cyc >= 1 && cyc <= 16) || (mem_rd_en && mem_addr !== 4'(cyc - 1))) rd_ok = 1'b0;
        if (err_pulse) begin
          if (cyc >= 2 && cyc <= 17) pmap[cyc-2] = 1'b1;
          else rd_ok = 1'b0;
        end
        if (done) begin
          chk("done_cycle", 32'(cyc), 18);
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_empty: got done with no expected sweep");
          end else begin
            last = sb.pop_front();
            chk("err_count", 32'(err_count), 32'(last.cnt));
            chk("first_err_valid", 32'(first_err_valid), 32'(last.fvalid));
            chk("first_err_addr", 32'(first_err_addr), 32'(last.faddr));
            chk("pulse_map", 32'(pmap), 32'(last.map));
            chk("read_sequence", 32'(rd_ok), 1);
`ifdef BERGER_SCRUB_ERRMAP_EN
            chk("err_map", 32'(err_map), 32'(last.map));
`endif
            post = 1'b1;
          end
          cyc = 0;
        end
      end else begin
        chk("idle_quiet", {29'd0, err_pulse, done, mem_rd_en}, 0);
      end
    end
  end

  task automatic fill_clean();
    for (int a = 0; a < N; a++) begin
      logic [7:0] d;
      d = 8'($urandom);
      mem[a] = {d, 4'($countones(d))};
    end
  endtask

  task automatic fill_random();
    fill_clean();
    for (int a = 0; a < N; a++)
      if ($urandom_range(3) == 0) begin
        logic [3:0] c;
        c = mem[a][3:0];
        while (c == mem[a][3:0]) c = 4'($urandom_range(15));
        mem[a][3:0] = c;
      end
  endtask

  task automatic run_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("sweep_timeout", 32'(busy), 0);
  endtask

  task automatic sweep();
    sb.push_back(model());
    run_start();
    wait_idle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_first_addr"}, 32'(first_err_addr), 0);
    chk({tag, "_first_valid"}, 32'(first_err_valid), 0);
`ifdef BERGER_SCRUB_ERRMAP_EN
    chk({tag, "_err_map"}, 32'(err_map), 0);
`endif
  endtask

  initial begin
    fill_clean();
    #2 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fill_clean();
    mem[3] = 12'hA54;
    sweep();
    fill_clean();
    mem[5] = 12'hA74;
    mem[12] = 12'h00F;
    sweep();
    for (int a = 0; a < N; a++) mem[a] = 12'hFF0;
    sweep();
    fill_random();
    sb.push_back(model());
    run_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    fill_random();
    mem[0][3:0] = mem[0][3:0] ^ 4'h8;
    sb.push_back(model());
    run_start();
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("midreset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    fill_random();
    sweep();
    fill_clean();
    mem[2][3:0] = mem[2][3:0] ^ 4'h8;
    mem[7][3:0] = mem[7][3:0] ^ 4'h8;
    mem[9][3:0] = mem[9][3:0] ^ 4'h8;
    sweep();
    fill_clean();
    sweep();
    for (int k = 0; k < 6; k++) begin
      fill_random();
      sweep();
    end
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
